// File: rtl/tile_ram_wr_ctrl_if.sv
// Port-A write bus between the cursor/clear sources and the tile RAM write controller.
// The master drives the request side, and the slave (the controller) drives the RAM port and status.
interface tile_ram_wr_ctrl_if;
    logic        clear_req;
    logic        trace_en;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [6:0]  ram_din;
    logic        busy;
    logic        clear_done;

    modport master (
        output clear_req, trace_en, cur_x, cur_y,
        input  ram_we, ram_addr, ram_din, busy, clear_done
    );

    modport slave (
        input  clear_req, trace_en, cur_x, cur_y,
        output ram_we, ram_addr, ram_din, busy, clear_done
    );
endinterface

// File: rtl/tile_ram_wr_ctrl.sv
// Single write-port owner for the 80x30 tile RAM: cursor trace writes plus a full-screen clear sweep.
// The sweep uses its own row/col counters, so the cursor position is never disturbed by a clear.
module tile_ram_wr_ctrl #(
    parameter logic [6:0] MAX_X      = 7'd79,
    parameter logic [4:0] MAX_Y      = 5'd29,
    parameter logic [6:0] TRACE_CHAR = 7'h01,
    parameter logic [6:0] BLANK_CHAR = 7'h00
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    tile_ram_wr_ctrl_if.slave  bus
);
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned DATA_W = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              clear_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              clear_edge_c;
    logic              trace_ok_c;

    assign clear_edge_c = bus.clear_req & ~clear_q;
    assign trace_ok_c   = bus.trace_en && (bus.cur_x <= MAX_X) && (bus.cur_y <= MAX_Y);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = {row_q, col_q};
                din_d  = BLANK_CHAR;
                busy_d = 1'b1;
                if (col_q == MAX_X) begin
                    col_d = '0;
                    if (row_q == MAX_Y) begin
                        row_d   = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end

            // Redraw the cursor cell the sweep just blanked
            ST_FLUSH: begin
                busy_d  = 1'b1;
                state_d = ST_IDLE;
                if (trace_ok_c) begin
                    we_d   = 1'b1;
                    addr_d = {bus.cur_y, bus.cur_x};
                    din_d  = TRACE_CHAR;
                end
            end

            default: begin
                // busy_q still high here only on the first cycle after FLUSH
                done_d = busy_q;
                busy_d = 1'b0;
                if (clear_edge_c) begin
                    state_d = ST_CLEAR;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    din_d   = BLANK_CHAR;
                    busy_d  = 1'b1;
                    row_d   = '0;
                    col_d   = COL_W'(1);
                end else if (trace_ok_c) begin
                    we_d   = 1'b1;
                    addr_d = {bus.cur_y, bus.cur_x};
                    din_d  = TRACE_CHAR;
                end
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            clear_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= BLANK_CHAR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            clear_q <= bus.clear_req;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ram_we     = we_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = din_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_tile_ram_wr_ctrl.sv
// Bench for tile_ram_wr_ctrl: a cycle reference model driven by randomized cursor traffic,
// plus per-sweep coverage of the written cells.
module tb_tile_ram_wr_ctrl;
    localparam int NCOL  = 80;
    localparam int NROW  = 30;
    localparam int NCELL = NCOL * NROW;

    logic clk_100MHz = 1'b0;
    logic reset;

    tile_ram_wr_ctrl_if bus();

    tile_ram_wr_ctrl dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: phase plus a linear index into the screen
    typedef enum int {M_IDLE, M_SWEEP, M_FLUSH, M_DONE} mphase_e;
    mphase_e     m_phase;
    int          m_k;
    bit          m_prev;
    bit          m_flush_wr;
    logic        e_we;
    logic [11:0] e_addr;
    logic [6:0]  e_din;
    logic        e_busy;
    logic        e_done;

    // Per-sweep scoreboard observed from the DUT outputs
    int blank_wr, distinct, bad_addr, trace_wr_busy, done_cnt, done_at;
    bit seen [4096];

    function automatic bit cursor_ok();
        return bus.trace_en && (int'(bus.cur_x) < NCOL) && (int'(bus.cur_y) < NROW);
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_k = 0; m_prev = 1'b0;
        e_we = 1'b0; e_addr = 12'h000; e_din = 7'h00; e_busy = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_step();
        bit clr_edge;
        clr_edge = bus.clear_req && !m_prev;
        m_prev   = bus.clear_req;
        e_done   = 1'b0;
        case (m_phase)
            M_SWEEP: begin
                e_we = 1'b1; e_din = 7'h00; e_busy = 1'b1;
                e_addr = 12'((m_k / NCOL) * 128 + (m_k % NCOL));
                m_k++;
                if (m_k == NCELL) m_phase = M_FLUSH;
            end
            M_FLUSH: begin
                e_busy = 1'b1;
                e_we = cursor_ok();
                m_flush_wr = e_we;
                if (e_we) begin e_addr = {bus.cur_y, bus.cur_x}; e_din = 7'h01; end
                m_phase = M_DONE;
            end
            default: begin
                e_done = (m_phase == M_DONE);
                e_busy = 1'b0;
                m_phase = M_IDLE;
                if (clr_edge) begin
                    e_we = 1'b1; e_addr = 12'h000; e_din = 7'h00; e_busy = 1'b1;
                    m_k = 1; m_phase = M_SWEEP;
                end else if (cursor_ok()) begin
                    e_we = 1'b1; e_addr = {bus.cur_y, bus.cur_x}; e_din = 7'h01;
                end else begin
                    e_we = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_scoreboard();
        blank_wr = 0; distinct = 0; bad_addr = 0; trace_wr_busy = 0; done_cnt = 0; done_at = -1;
        m_flush_wr = 1'b0;
        foreach (seen[i]) seen[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        model_step();
        @(negedge clk_100MHz);
        check("ram_we",     32'(bus.ram_we),     32'(e_we));
        check("ram_addr",   32'(bus.ram_addr),   32'(e_addr));
        check("ram_din",    32'(bus.ram_din),    32'(e_din));
        check("busy",       32'(bus.busy),       32'(e_busy));
        check("clear_done", 32'(bus.clear_done), 32'(e_done));
        if (bus.ram_we === 1'b1 && bus.busy === 1'b1 && bus.ram_din === 7'h00) begin
            blank_wr++;
            if (!seen[bus.ram_addr]) distinct++;
            seen[bus.ram_addr] = 1'b1;
            if (int'(bus.ram_addr[6:0]) >= NCOL || int'(bus.ram_addr[11:7]) >= NROW) bad_addr++;
        end
        if (bus.ram_we === 1'b1 && bus.busy === 1'b1 && bus.ram_din === 7'h01) trace_wr_busy++;
        if (bus.clear_done === 1'b1) done_cnt++;
    endtask

    task automatic rand_cursor(input bit in_range);
        bus.trace_en = in_range ? 1'b1 : 1'($urandom_range(0, 1));
        bus.cur_x = in_range ? 7'($urandom_range(0, NCOL - 1)) : 7'($urandom_range(0, 127));
        bus.cur_y = in_range ? 5'($urandom_range(0, NROW - 1)) : 5'($urandom_range(0, 31));
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop before any clock edge
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_we",   32'(bus.ram_we),     32'd0);
        check("rst_addr", 32'(bus.ram_addr),   32'h000);
        check("rst_din",  32'(bus.ram_din),    32'h00);
        check("rst_busy", 32'(bus.busy),       32'd0);
        check("rst_done", 32'(bus.clear_done), 32'd0);
        model_reset();
        @(negedge clk_100MHz);
        reset = 1'b0;
    endtask

    // Ticks until clear_done; i counts posedges after the edge-detect posedge
    task automatic run_until_done(input bit wiggle, input bit repulse);
        for (int i = 1; i <= 3000; i++) begin
            if (wiggle) rand_cursor(1'b1);
            if (repulse) bus.clear_req = (i == 500);
            tick();
            if (bus.clear_done === 1'b1) begin done_at = i; break; end
        end
        check("done_latency", 32'(done_at), 32'd2401);
    endtask

    initial begin
        bus.clear_req = 1'b0; bus.trace_en = 1'b0; bus.cur_x = 7'd0; bus.cur_y = 5'd0;
        reset = 1'b1;
        model_reset();
        clear_scoreboard();
        #12;
        check("por_we",   32'(bus.ram_we),   32'd0);
        check("por_addr", 32'(bus.ram_addr), 32'h000);
        check("por_din",  32'(bus.ram_din),  32'h00);
        check("por_busy", 32'(bus.busy),     32'd0);
        @(negedge clk_100MHz);
        reset = 1'b0;

        // Single trace write and its removal
        bus.trace_en = 1'b1; bus.cur_x = 7'd35; bus.cur_y = 5'd15;
        tick();
        check("trace_35_15_addr", 32'(bus.ram_addr), 32'h7A3);
        bus.trace_en = 1'b0;
        tick();
        check("trace_off_we", 32'(bus.ram_we), 32'd0);

        // Out-of-range cursor
        bus.trace_en = 1'b1; bus.cur_x = 7'd80; bus.cur_y = 5'd3;
        tick();
        bus.cur_x = 7'd79; bus.cur_y = 5'd30;
        tick();
        bus.cur_x = 7'd79; bus.cur_y = 5'd29;
        tick();
        check("trace_corner_addr", 32'(bus.ram_addr), 32'hECF);

        repeat (40) begin rand_cursor(1'b0); tick(); end

        // Sweep with a moving cursor and a stray clear pulse
        clear_scoreboard();
        rand_cursor(1'b1);
        bus.clear_req = 1'b1;
        tick();
        check("sweep_first_addr", 32'(bus.ram_addr), 32'h000);
        bus.clear_req = 1'b0;
        run_until_done(1'b1, 1'b1);
        check("sweep1_blank_writes", 32'(blank_wr), 32'(NCELL));
        check("sweep1_distinct", 32'(distinct), 32'(NCELL));
        check("sweep1_bad_addr", 32'(bad_addr), 32'd0);
        check("sweep1_trace_in_busy", 32'(trace_wr_busy), 32'd1);
        check("sweep1_flush_seen", 32'(m_flush_wr), 32'd1);
        repeat (10) begin rand_cursor(1'b1); tick(); end
        check("sweep1_done_count", 32'(done_cnt), 32'd1);

        // clear_req held high for 5000 cycles with one dip mid-sweep
        clear_scoreboard();
        bus.trace_en = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            bus.clear_req = (i != 1000);
            if (i[3:0] == 4'd0) rand_cursor(1'b0);
            tick();
        end
        bus.clear_req = 1'b0;
        check("hold_blank_writes", 32'(blank_wr), 32'(NCELL));
        check("hold_done_count", 32'(done_cnt), 32'd1);
        repeat (4) tick();

        // Reset at sweep write 1000 with clear_req low
        clear_scoreboard();
        bus.trace_en = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (999) tick();
        check("abort_write_count", 32'(blank_wr), 32'd1000);
        async_reset();
        bus.trace_en = 1'b1; bus.cur_x = 7'd5; bus.cur_y = 5'd2;
        tick();
        check("abort_trace_addr", 32'(bus.ram_addr), 32'h105);
        check("abort_trace_din", 32'(bus.ram_din), 32'h01);
        repeat (20) begin rand_cursor(1'b0); tick(); end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // Reset at sweep write 1000 with clear_req still high
        clear_scoreboard();
        bus.clear_req = 1'b1;
        tick();
        repeat (999) tick();
        async_reset();
        clear_scoreboard();
        tick();
        check("restart_we", 32'(bus.ram_we), 32'd1);
        check("restart_addr", 32'(bus.ram_addr), 32'h000);
        check("restart_busy", 32'(bus.busy), 32'd1);
        bus.clear_req = 1'b0;
        run_until_done(1'b1, 1'b0);
        check("restart_blank_writes", 32'(blank_wr), 32'(NCELL));
        check("restart_done_count", 32'(done_cnt), 32'd1);
        repeat (5) begin rand_cursor(1'b0); tick(); end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
